// File: rtl/branch_pkg.sv
// Shared branch-unit types: funct3 encodings, branch-op enum and the result bundle.
package branch_pkg;

    localparam int unsigned BR_XLEN_MAX = 64;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [2:0] {
        BR_BEQ  = F3_BEQ,
        BR_BNE  = F3_BNE,
        BR_RSV2 = 3'b010,
        BR_RSV3 = 3'b011,
        BR_BLT  = F3_BLT,
        BR_BGE  = F3_BGE,
        BR_BLTU = F3_BLTU,
        BR_BGEU = F3_BGEU
    } branch_op_e;

    // Sized for the widest legal XLEN; narrower units use the low bits only.
    typedef struct packed {
        logic                   taken;
        logic [BR_XLEN_MAX-1:0] target;
        logic [BR_XLEN_MAX-1:0] redirect;
        logic                   mispredict;
        logic                   illegal;
    } branch_res_t;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch comparator: funct3 decode to taken/illegal.
module branch_cmp
    import branch_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      funct3,
    output logic            taken,
    output logic            illegal
);

    branch_op_e op;
    assign op = branch_op_e'(funct3);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (op)
            BR_BEQ:  taken = (rs1 == rs2);
            BR_BNE:  taken = (rs1 != rs2);
            BR_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            BR_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            BR_BLTU: taken = (rs1 <  rs2);
            BR_BGEU: taken = (rs1 >= rs2);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Pipelined branch-resolution unit (1 or 2 stages) with valid/ready handshake and flush.
// Optional saturating statistics counters when BRANCH_STATS_EN is defined.
module branch_unit
    import branch_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAGES = 1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_pred,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_redirect,
    output logic            out_mispredict,
`ifdef BRANCH_STATS_EN
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_taken,
    output logic [CNT_W-1:0] stat_mispredict,
`endif
    output logic            out_illegal
);

    logic            cmp_taken;
    logic            cmp_illegal;
    logic [XLEN-1:0] target_c;
    logic [XLEN-1:0] pc4_c;
    logic            accept;
    logic            out_adv;
    logic            out_valid_q;
    logic            out_load;
    branch_res_t     res_d;
    branch_res_t     res_q;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .funct3  (in_funct3),
        .taken   (cmp_taken),
        .illegal (cmp_illegal)
    );

    assign target_c = in_pc + in_imm;
    assign pc4_c    = in_pc + XLEN'(4);
    assign accept   = in_valid && in_ready;
    assign out_adv  = !out_valid_q || out_ready;

    generate
        if (STAGES == 1) begin : g_one
            assign in_ready = out_adv;
            assign out_load = accept;

            always_comb begin
                res_d            = '0;
                res_d.taken      = cmp_taken;
                res_d.target     = BR_XLEN_MAX'(target_c);
                res_d.redirect   = cmp_taken ? BR_XLEN_MAX'(target_c) : BR_XLEN_MAX'(pc4_c);
                res_d.mispredict = !cmp_illegal && (cmp_taken != in_pred);
                res_d.illegal    = cmp_illegal;
            end
        end else begin : g_two
            logic            s1_valid_q;
            logic            s1_taken_q;
            logic            s1_pred_q;
            logic            s1_illegal_q;
            logic [XLEN-1:0] s1_target_q;
            logic [XLEN-1:0] s1_pc4_q;
            logic            s1_adv;

            assign s1_adv   = !s1_valid_q || out_adv;
            assign in_ready = s1_adv;
            assign out_load = s1_valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_valid_q   <= 1'b0;
                    s1_taken_q   <= 1'b0;
                    s1_pred_q    <= 1'b0;
                    s1_illegal_q <= 1'b0;
                    s1_target_q  <= '0;
                    s1_pc4_q     <= '0;
                end else begin
                    if (flush) begin
                        s1_valid_q <= 1'b0;
                    end else if (s1_adv) begin
                        s1_valid_q <= accept;
                    end
                    if (accept) begin
                        s1_taken_q   <= cmp_taken;
                        s1_pred_q    <= in_pred;
                        s1_illegal_q <= cmp_illegal;
                        s1_target_q  <= target_c;
                        s1_pc4_q     <= pc4_c;
                    end
                end
            end

            always_comb begin
                res_d            = '0;
                res_d.taken      = s1_taken_q;
                res_d.target     = BR_XLEN_MAX'(s1_target_q);
                res_d.redirect   = s1_taken_q ? BR_XLEN_MAX'(s1_target_q) : BR_XLEN_MAX'(s1_pc4_q);
                res_d.mispredict = !s1_illegal_q && (s1_taken_q != s1_pred_q);
                res_d.illegal    = s1_illegal_q;
            end
        end
    endgenerate

    // Output register is the last stage in both configurations; flush only clears valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (out_adv) begin
                out_valid_q <= out_load;
            end
            if (out_adv && out_load) begin
                res_q <= res_d;
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign out_taken      = res_q.taken;
    assign out_target     = res_q.target[XLEN-1:0];
    assign out_redirect   = res_q.redirect[XLEN-1:0];
    assign out_mispredict = res_q.mispredict;
    assign out_illegal    = res_q.illegal;

    generate
        if (XLEN < BR_XLEN_MAX) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^{res_q.target[BR_XLEN_MAX-1:XLEN], res_q.redirect[BR_XLEN_MAX-1:XLEN]};
        end
    endgenerate

`ifdef BRANCH_STATS_EN
    logic             stat_hit;
    logic [CNT_W-1:0] st_br_q;
    logic [CNT_W-1:0] st_tk_q;
    logic [CNT_W-1:0] st_mp_q;

    assign stat_hit = out_valid_q && out_ready && !res_q.illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_br_q <= '0;
            st_tk_q <= '0;
            st_mp_q <= '0;
        end else if (stat_clr) begin
            st_br_q <= '0;
            st_tk_q <= '0;
            st_mp_q <= '0;
        end else if (stat_hit) begin
            if (st_br_q != '1) st_br_q <= st_br_q + CNT_W'(1);
            if (res_q.taken && (st_tk_q != '1)) st_tk_q <= st_tk_q + CNT_W'(1);
            if (res_q.mispredict && (st_mp_q != '1)) st_mp_q <= st_mp_q + CNT_W'(1);
        end
    end

    assign stat_branches   = st_br_q;
    assign stat_taken      = st_tk_q;
    assign stat_mispredict = st_mp_q;
`else
    logic [CNT_W-1:0] stat_unused;
    assign stat_unused = '0;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench: instance a is STAGES=1, instance b is STAGES=2.
module tb_branch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] rs1, rs2, pc, imm;
    logic [2:0]  f3;
    logic        pred;

    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic        a_taken, a_mis, a_ill;
    logic [31:0] a_target, a_redirect;
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic        b_taken, b_mis, b_ill;
    logic [31:0] b_target, b_redirect;

    int checks = 0;
    int errors = 0;

`ifdef BRANCH_STATS_EN
    logic       a_clr, b_clr;
    logic [3:0] a_sb, a_st, a_sm, b_sb, b_st, b_sm;
`endif

    branch_unit #(.XLEN(32), .STAGES(1)
`ifdef BRANCH_STATS_EN
        , .CNT_W(4)
`endif
    ) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_rs1(rs1), .in_rs2(rs2), .in_funct3(f3), .in_pc(pc), .in_imm(imm), .in_pred(pred),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_taken(a_taken),
        .out_target(a_target), .out_redirect(a_redirect), .out_mispredict(a_mis),
`ifdef BRANCH_STATS_EN
        .stat_clr(a_clr), .stat_branches(a_sb), .stat_taken(a_st), .stat_mispredict(a_sm),
`endif
        .out_illegal(a_ill)
    );

    branch_unit #(.XLEN(32), .STAGES(2)
`ifdef BRANCH_STATS_EN
        , .CNT_W(4)
`endif
    ) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_rs1(rs1), .in_rs2(rs2), .in_funct3(f3), .in_pc(pc), .in_imm(imm), .in_pred(pred),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_taken(b_taken),
        .out_target(b_target), .out_redirect(b_redirect), .out_mispredict(b_mis),
`ifdef BRANCH_STATS_EN
        .stat_clr(b_clr), .stat_branches(b_sb), .stat_taken(b_st), .stat_mispredict(b_sm),
`endif
        .out_illegal(b_ill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] f, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] p, input logic [31:0] im, input logic pr);
        f3 = f; rs1 = r1; rs2 = r2; pc = p; imm = im; pred = pr;
    endtask

    task automatic a_op(input string tag, input logic [2:0] f, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] p, input logic [31:0] im,
                        input logic pr, input logic e_tk, input logic [31:0] e_tgt,
                        input logic [31:0] e_rd, input logic e_mis, input logic e_ill);
        drive(f, r1, r2, p, im, pr);
        a_in_valid  = 1'b1;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        chk({tag, "_valid"}, a_out_valid, 1'b1);
        chk({tag, "_taken"}, a_taken, e_tk);
        chk({tag, "_target"}, a_target, e_tgt);
        chk({tag, "_redirect"}, a_redirect, e_rd);
        chk({tag, "_mis"}, a_mis, e_mis);
        chk({tag, "_ill"}, a_ill, e_ill);
    endtask

    initial begin
        logic [31:0] exp_rd;
        rst_n = 1'b0;
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
`ifdef BRANCH_STATS_EN
        a_clr = 1'b0; b_clr = 1'b0;
`endif
        drive(3'b000, '0, '0, '0, '0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_valid", a_out_valid, 1'b0);
        chk("rst_a_target", a_target, 32'h0);
        chk("rst_a_redirect", a_redirect, 32'h0);
        chk("rst_b_valid", b_out_valid, 1'b0);
        chk("rst_b_taken", b_taken, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_a_in_ready", a_in_ready, 1'b1);
        chk("rst_b_in_ready", b_in_ready, 1'b1);

        // STAGES=1 decode and arithmetic
        a_op("blt",  3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 1'b1, 32'h120, 32'h120, 1'b1, 1'b0);
        a_op("bltu", 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 1'b0, 32'h120, 32'h104, 1'b0, 1'b0);
        a_op("ill2", 3'b010, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b1, 1'b0, 32'h120, 32'h104, 1'b0, 1'b1);
        a_op("ill3", 3'b011, 32'h5, 32'h5, 32'h200, 32'h8, 1'b0, 1'b0, 32'h208, 32'h204, 1'b0, 1'b1);
        a_op("beq",  3'b000, 32'h5, 32'h5, 32'h200, 32'h8, 1'b1, 1'b1, 32'h208, 32'h208, 1'b0, 1'b0);
        a_op("bne",  3'b001, 32'h5, 32'h5, 32'h200, 32'h8, 1'b1, 1'b0, 32'h208, 32'h204, 1'b1, 1'b0);
        a_op("bge",  3'b101, 32'hFFFF_FFFF, 32'h1, 32'h300, 32'hFFFF_FFF0, 1'b0, 1'b0, 32'h2F0, 32'h304, 1'b0, 1'b0);
        a_op("bgeu", 3'b111, 32'hFFFF_FFFF, 32'h1, 32'h300, 32'hFFFF_FFF0, 1'b0, 1'b1, 32'h2F0, 32'h2F0, 1'b1, 1'b0);
        a_op("wrapt", 3'b001, 32'h1, 32'h2, 32'hFFFF_FFFC, 32'h8, 1'b1, 1'b1, 32'h4, 32'h4, 1'b0, 1'b0);
        a_op("wrap4", 3'b000, 32'h1, 32'h2, 32'hFFFF_FFFC, 32'h8, 1'b0, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("a_empty_valid", a_out_valid, 1'b0);
        chk("a_empty_ready", a_in_ready, 1'b1);

        // STAGES=2 back-to-back: item i taken when i is even
        b_out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                drive(3'b000, 32'(c), (c % 2 == 0) ? 32'(c) : 32'(c + 1),
                      32'h1000 + 32'(16 * c), 32'h40, 1'b0);
                b_in_valid = 1'b1;
                #1;
                chk("b2b_in_ready", b_in_ready, 1'b1);
            end else begin
                b_in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (c == 0 || c == 9) begin
                chk("b2b_idle_valid", b_out_valid, 1'b0);
            end else begin
                exp_rd = ((c - 1) % 2 == 0) ? 32'h1040 + 32'(16 * (c - 1)) : 32'h1004 + 32'(16 * (c - 1));
                chk("b2b_valid", b_out_valid, 1'b1);
                chk("b2b_taken", b_taken, ((c - 1) % 2 == 0) ? 1'b1 : 1'b0);
                chk("b2b_redirect", b_redirect, exp_rd);
            end
        end

        // STAGES=2 back-pressure
        b_out_ready = 1'b0;
        drive(3'b000, 32'h1, 32'h1, 32'h2000, 32'h10, 1'b1);
        b_in_valid = 1'b1;
        #1 chk("bp_ready_a", b_in_ready, 1'b1);
        @(posedge clk); #1;
        drive(3'b000, 32'h1, 32'h2, 32'h3000, 32'h10, 1'b0);
        chk("bp_ready_b", b_in_ready, 1'b1);
        @(posedge clk); #1;
        drive(3'b001, 32'h1, 32'h1, 32'h4000, 32'h10, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk("bp_full_ready", b_in_ready, 1'b0);
            chk("bp_hold_valid", b_out_valid, 1'b1);
            chk("bp_hold_redirect", b_redirect, 32'h2010);
            chk("bp_hold_taken", b_taken, 1'b1);
            @(posedge clk); #1;
        end
        b_out_ready = 1'b1;
        #1 chk("bp_release_ready", b_in_ready, 1'b1);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        chk("bp_drain_b_valid", b_out_valid, 1'b1);
        chk("bp_drain_b_redirect", b_redirect, 32'h3004);
        @(posedge clk); #1;
        chk("bp_drain_c_valid", b_out_valid, 1'b1);
        chk("bp_drain_c_redirect", b_redirect, 32'h4004);
        @(posedge clk); #1;
        chk("bp_drained", b_out_valid, 1'b0);

        // Flush with two in flight plus a new request
        drive(3'b000, 32'h7, 32'h7, 32'h5000, 32'h20, 1'b0);
        b_in_valid = 1'b1;
        @(posedge clk); #1;
        drive(3'b000, 32'h7, 32'h7, 32'h6000, 32'h20, 1'b0);
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        chk("fl_pre_valid", b_out_valid, 1'b1);
        drive(3'b000, 32'h7, 32'h7, 32'h7000, 32'h20, 1'b0);
        b_flush = 1'b1;
        @(posedge clk); #1;
        b_flush = 1'b0;
        b_in_valid = 1'b0;
        chk("fl_valid", b_out_valid, 1'b0);
        chk("fl_in_ready", b_in_ready, 1'b1);
        b_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("fl_no_ghost", b_out_valid, 1'b0);
        end

        // Asynchronous reset mid-stream
        drive(3'b000, 32'h3, 32'h3, 32'h8000, 32'h40, 1'b0);
        b_in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        chk("ar_pre_valid", b_out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", b_out_valid, 1'b0);
        chk("ar_redirect", b_redirect, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ar_in_ready", b_in_ready, 1'b1);

`ifdef BRANCH_STATS_EN
        a_out_ready = 1'b1;
        drive(3'b000, 32'h9, 32'h9, 32'h100, 32'h20, 1'b0);
        a_in_valid = 1'b1;
        repeat (20) @(posedge clk);
        #1 a_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("st_branches_sat", a_sb, 4'hF);
        chk("st_taken_sat", a_st, 4'hF);
        chk("st_mis_sat", a_sm, 4'hF);
        a_clr = 1'b1;
        @(posedge clk); #1;
        a_clr = 1'b0;
        chk("st_branches_clr", a_sb, 4'h0);
        chk("st_taken_clr", a_st, 4'h0);
        chk("st_mis_clr", a_sm, 4'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
